cam_pixel_capture: RTL and testbench



---
 rtl/cam_pkg.sv | 16 +
 rtl/cam_sync_edge.sv | 41 ++++
 rtl/cam_pixel_capture.sv | 190 +++++++++++++++++++
 tb/tb_cam_pixel_capture.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared constants and state type for the camera pixel capture block
package cam_pkg;

   localparam int IMG_W_DEF = 640;
   localparam int IMG_H_DEF = 480;
   localparam int COORD_W   = 10;
   localparam int COORD_MAX = (1 << COORD_W) - 1;

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      VBLANK = 2'd1,
      ACTIVE = 2'd2,
      DONE   = 2'd3
   } cam_state_e;

endpackage

// File: rtl/cam_sync_edge.sv
// rtl/cam_sync_edge.sv - registered vsync/href copies and their rise/fall strobes
module cam_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic vsync,
   input  logic href,
   output logic vsync_rise,
   output logic vsync_fall,
   output logic href_rise,
   output logic href_fall
);

   logic vsync_q, vsync_d;
   logic href_q, href_d;

   // delayed copies simply follow the camera inputs
   always_comb begin
      vsync_d = vsync;
      href_d  = href;
   end

   // one-cycle history of the sync lines, cleared by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         vsync_q <= 1'b0;
         href_q  <= 1'b0;
      end else begin
         vsync_q <= vsync_d;
         href_q  <= href_d;
      end
   end

   // edge strobes compare the live input against its registered copy
   always_comb begin
      vsync_rise = vsync & ~vsync_q;
      vsync_fall = ~vsync & vsync_q;
      href_rise  = href & ~href_q;
      href_fall  = ~href & href_q;
   end

endmodule

// File: rtl/cam_pixel_capture.sv
// rtl/cam_pixel_capture.sv - camera YUV422 byte stream to luma pixel stream with frame status
module cam_pixel_capture
   import cam_pkg::*;
#(
   parameter int IMG_W   = IMG_W_DEF,
   parameter int IMG_H   = IMG_H_DEF,
   parameter bit Y_FIRST = 1'b1
) (
   input  logic               pclk,
   input  logic               reset,
   input  logic               vsync,
   input  logic               href,
   input  logic [7:0]         d,
   output logic [7:0]         value,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               is_val,
   output logic               frame_done,
   output logic               frame_err
);

   localparam logic [COORD_W-1:0] W_C        = COORD_W'(IMG_W);
   localparam logic [COORD_W-1:0] H_C        = COORD_W'(IMG_H);
   localparam logic               LUMA_PHASE = !Y_FIRST;

   generate
      if (IMG_W < 1 || IMG_W > COORD_MAX || IMG_H < 1 || IMG_H > COORD_MAX) begin : g_bad_size
         $error("cam_pixel_capture: IMG_W and IMG_H must be in 1..%0d", COORD_MAX);
      end
   endgenerate

   logic vsync_rise, vsync_fall, href_rise, href_fall;

   cam_sync_edge u_sync_edge (
      .clk        (pclk),
      .reset      (reset),
      .vsync      (vsync),
      .href       (href),
      .vsync_rise (vsync_rise),
      .vsync_fall (vsync_fall),
      .href_rise  (href_rise),
      .href_fall  (href_fall)
   );

   cam_state_e         state_q, state_d;
   logic [COORD_W-1:0] col_q, col_d;
   logic [COORD_W-1:0] row_q, row_d;
   logic               phase_q, phase_d;
   logic               err_q, err_d;
   logic [7:0]         value_q, value_d;
   logic [COORD_W-1:0] x_q, x_d;
   logic [COORD_W-1:0] y_q, y_d;
   logic               is_val_q, is_val_d;
   logic               frame_done_q, frame_done_d;
   logic               frame_err_q, frame_err_d;

   logic               in_active;
   logic               byte_phase;
   logic               luma_byte;
   logic               pix_ok;
   logic               line_end;
   logic               line_err;
   logic [COORD_W-1:0] row_inc;
   logic               frame_last;
   logic               truncate;

   // classify the current byte and the line/frame boundary events
   always_comb begin
      in_active  = (state_q == ACTIVE);
      byte_phase = href_rise ? 1'b0 : phase_q;
      luma_byte  = in_active && href && (byte_phase == LUMA_PHASE);
      pix_ok     = (col_q < W_C);
      line_end   = in_active && href_fall;
      line_err   = line_end && (col_q != W_C);
      row_inc    = row_q + 1'b1;
      frame_last = line_end && (row_inc == H_C);
      // a line end that completes the frame takes priority over a truncating vsync
      truncate   = in_active && vsync_rise && !frame_last;
   end

   // state register
   always_ff @(posedge pclk) begin
      if (reset) begin
         state_q <= SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state selection
   always_comb begin
      state_d = state_q;
      case (state_q)
         SYNC:    if (vsync) state_d = VBLANK;
         VBLANK:  if (vsync_fall) state_d = ACTIVE;
         ACTIVE: begin
            if (frame_last) begin
               state_d = DONE;
            end else if (vsync_rise) begin
               state_d = VBLANK;
            end
         end
         DONE:    if (vsync) state_d = VBLANK;
         default: state_d = SYNC;
      endcase
   end

   // pixel counters, luma capture and frame status outputs
   always_comb begin
      col_d        = col_q;
      row_d        = row_q;
      phase_d      = phase_q;
      err_d        = err_q;
      value_d      = value_q;
      x_d          = x_q;
      y_d          = y_q;
      is_val_d     = 1'b0;
      frame_done_d = 1'b0;
      frame_err_d  = 1'b0;

      if (state_q == VBLANK && vsync_fall) begin
         col_d   = '0;
         row_d   = '0;
         phase_d = 1'b0;
         err_d   = 1'b0;
      end

      if (in_active && href) begin
         phase_d = ~byte_phase;
         if (luma_byte) begin
            if (pix_ok) begin
               is_val_d = 1'b1;
               value_d  = d;
               x_d      = col_q;
               y_d      = row_q;
               col_d    = col_q + 1'b1;
            end else begin
               err_d = 1'b1;
            end
         end
      end

      if (line_end) begin
         col_d = '0;
         row_d = row_inc;
         if (line_err) err_d = 1'b1;
         if (frame_last) begin
            frame_done_d = 1'b1;
            frame_err_d  = err_q | line_err;
         end
      end

      if (truncate) frame_err_d = 1'b1;
   end

   // datapath registers
   always_ff @(posedge pclk) begin
      if (reset) begin
         col_q        <= '0;
         row_q        <= '0;
         phase_q      <= 1'b0;
         err_q        <= 1'b0;
         value_q      <= '0;
         x_q          <= '0;
         y_q          <= '0;
         is_val_q     <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         phase_q      <= phase_d;
         err_q        <= err_d;
         value_q      <= value_d;
         x_q          <= x_d;
         y_q          <= y_d;
         is_val_q     <= is_val_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign value      = value_q;
   assign x          = x_q;
   assign y          = y_q;
   assign is_val     = is_val_q;
   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// tb/tb_cam_pixel_capture.sv - directed self-checking bench for cam_pixel_capture
module tb_cam_pixel_capture;

   logic       pclk = 1'b0;
   logic       reset = 1'b1;
   logic       vsync = 1'b0;
   logic       href = 1'b0;
   logic [7:0] d = 8'd0;
   logic       sel = 1'b0;

   logic [7:0] v1, v0;
   logic [9:0] x1, x0, y1, y0;
   logic       iv1, iv0, fd1, fd0, fe1, fe0;

   cam_pixel_capture #(.IMG_W(4), .IMG_H(2), .Y_FIRST(1'b1)) dut_y1 (
      .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .d(d),
      .value(v1), .x(x1), .y(y1), .is_val(iv1), .frame_done(fd1), .frame_err(fe1)
   );

   cam_pixel_capture #(.IMG_W(4), .IMG_H(2), .Y_FIRST(1'b0)) dut_y0 (
      .pclk(pclk), .reset(reset), .vsync(vsync), .href(href), .d(d),
      .value(v0), .x(x0), .y(y0), .is_val(iv0), .frame_done(fd0), .frame_err(fe0)
   );

   logic [7:0] m_value;
   logic [9:0] m_x, m_y;
   logic       m_is_val, m_done, m_err;

   assign m_value  = sel ? v0  : v1;
   assign m_x      = sel ? x0  : x1;
   assign m_y      = sel ? y0  : y1;
   assign m_is_val = sel ? iv0 : iv1;
   assign m_done   = sel ? fd0 : fd1;
   assign m_err    = sel ? fe0 : fe1;

   always #5 pclk = ~pclk;

   typedef struct {
      logic [7:0] v;
      int         x;
      int         y;
      int         c;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n_done = 0;
   int   n_ferr = 0;

   always @(posedge pclk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // compare every strobe of the selected instance against the expectation queue
   always @(negedge pclk) begin
      if (m_is_val === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("value", 32'(m_value), 32'(e.v));
            chk("x", 32'(m_x), e.x);
            chk("y", 32'(m_y), e.y);
            chk("latency", cyc, e.c);
         end
      end
      if (m_done === 1'b1) n_done++;
      if (m_err === 1'b1) n_ferr++;
   end

   task automatic vsync_pulse();
      href  = 1'b0;
      vsync = 1'b1;
      repeat (3) @(negedge pclk);
      vsync = 1'b0;
      repeat (3) @(negedge pclk);
   endtask

   // one line of npix pixels; luma of pixel p on row r is 10 + 4*r + p
   task automatic send_line(input int npix, input int row, input bit luma_first,
                            input bit vs_end, input bit expect_en);
      for (int p = 0; p < npix; p++) begin
         for (int b = 0; b < 2; b++) begin
            logic [7:0] lv;
            bit         is_l;
            lv   = 8'(10 + row * 4 + p);
            is_l = ((b == 0) == luma_first);
            href = 1'b1;
            d    = is_l ? lv : ((p % 2 == 0) ? 8'h80 : 8'h81);
            if (is_l && p < 4 && expect_en)
               exp_q.push_back('{v: lv, x: p, y: row, c: cyc + 1});
            @(negedge pclk);
         end
      end
      href  = 1'b0;
      vsync = vs_end;
      d     = 8'd0;
      repeat (3) @(negedge pclk);
   endtask

   task automatic end_scn(input string name, input int exp_done, input int exp_err);
      repeat (4) @(negedge pclk);
      chk({name, "_frame_done"}, n_done, exp_done);
      chk({name, "_frame_err"}, n_ferr, exp_err);
      chk({name, "_pending"}, exp_q.size(), 0);
      n_done = 0;
      n_ferr = 0;
      exp_q.delete();
   endtask

   initial begin
      // reset state from power-up
      repeat (3) @(negedge pclk);
      chk("rst_value", 32'(m_value), 0);
      chk("rst_x", 32'(m_x), 0);
      chk("rst_y", 32'(m_y), 0);
      chk("rst_is_val", 32'(m_is_val), 0);
      chk("rst_frame_done", 32'(m_done), 0);
      chk("rst_frame_err", 32'(m_err), 0);
      reset = 1'b0;
      repeat (2) @(negedge pclk);

      // clean YUYV frame, then a line during DONE that must be ignored
      vsync_pulse();
      send_line(4, 0, 1'b1, 1'b0, 1'b1);
      send_line(4, 1, 1'b1, 1'b0, 1'b1);
      send_line(4, 0, 1'b1, 1'b0, 1'b0);
      end_scn("s1", 1, 0);

      // clean UYVY frame on the Y_FIRST=0 instance
      sel = 1'b1;
      vsync_pulse();
      send_line(4, 0, 1'b0, 1'b0, 1'b1);
      send_line(4, 1, 1'b0, 1'b0, 1'b1);
      end_scn("s2", 1, 0);
      sel = 1'b0;

      // short first line
      vsync_pulse();
      send_line(3, 0, 1'b1, 1'b0, 1'b1);
      send_line(4, 1, 1'b1, 1'b0, 1'b1);
      end_scn("s3", 1, 1);

      // truncated frame, then a clean restart
      vsync_pulse();
      send_line(4, 0, 1'b1, 1'b0, 1'b1);
      vsync_pulse();
      end_scn("s4_trunc", 0, 1);
      send_line(4, 0, 1'b1, 1'b0, 1'b1);
      send_line(4, 1, 1'b1, 1'b0, 1'b1);
      end_scn("s4_restart", 1, 0);

      // reset in the middle of streaming data; nothing until a vsync sequence
      href = 1'b1;
      for (int i = 0; i < 12; i++) begin
         d     = 8'(40 + i);
         reset = (i >= 3 && i < 6);
         @(negedge pclk);
         if (i == 3) begin
            chk("midrst_value", 32'(m_value), 0);
            chk("midrst_x", 32'(m_x), 0);
            chk("midrst_y", 32'(m_y), 0);
            chk("midrst_is_val", 32'(m_is_val), 0);
         end
      end
      href = 1'b0;
      repeat (2) @(negedge pclk);
      send_line(4, 1, 1'b1, 1'b0, 1'b0);
      end_scn("s5_junk", 0, 0);
      vsync_pulse();
      send_line(4, 0, 1'b1, 1'b0, 1'b1);
      send_line(4, 1, 1'b1, 1'b0, 1'b1);
      end_scn("s5", 1, 0);

      // long first line: extra pixels dropped and flagged
      vsync_pulse();
      send_line(6, 0, 1'b1, 1'b0, 1'b1);
      send_line(4, 1, 1'b1, 1'b0, 1'b1);
      end_scn("s6", 1, 1);

      // last line end coinciding with vsync rise: completion wins
      vsync_pulse();
      send_line(4, 0, 1'b1, 1'b0, 1'b1);
      send_line(4, 1, 1'b1, 1'b1, 1'b1);
      end_scn("s7_done", 1, 0);

      // non-final line end coinciding with vsync rise: truncation
      vsync_pulse();
      send_line(4, 0, 1'b1, 1'b1, 1'b1);
      end_scn("s7_trunc", 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
